// File: rtl/unary_to_binary_array_pkg.sv
// Shared definitions for the unary-to-binary lane array: FSM state encoding,
// default geometry and the two's-complement saturation limits.
package unary_to_binary_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_DIM   = 4;
    localparam int DEFAULT_WIDTH = 8;

    // Limits for the default accumulator width.
    localparam int SAT_MAX = (2 ** (DEFAULT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DEFAULT_WIDTH - 1));

    // Largest positive value representable in a w-bit two's-complement word.
    function automatic longint sat_max_of(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a w-bit two's-complement word.
    function automatic longint sat_min_of(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/unary_to_binary_array_lane.sv
// One lane: saturating up/down counter of unary pulses with a sticky
// saturation flag. Clear has priority over a counting step.
module unary_acc_lane
    import unary_to_binary_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] ACC_MAX = WIDTH'(sat_max_of(WIDTH));
    localparam logic [WIDTH-1:0] ACC_MIN = WIDTH'(sat_min_of(WIDTH));
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_acc;
    logic             r_sat;
    logic             w_at_limit;

    // A step is blocked when the accumulator already sits on the limit it moves toward.
    assign w_at_limit = i_neg ? (r_acc == ACC_MIN) : (r_acc == ACC_MAX);

    // Accumulator and sticky flag update; a blocked step only raises the flag.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_step) begin
            if (w_at_limit) begin
                r_sat <= 1'b1;
            end else if (i_neg) begin
                r_acc <= r_acc - ONE;
            end else begin
                r_acc <= r_acc + ONE;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/unary_to_binary_array.sv
// Array of DIM unary-pulse accumulators framed by start/last, with a
// valid/ready output handshake. The frame FSM lives here; lanes are counters.
module unary_to_binary_array
    import unary_to_binary_array_pkg::*;
#(
    parameter int DIM   = DEFAULT_DIM,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      en,
    input  logic [DIM-1:0]            unary_in,
    input  logic [DIM-1:0]            neg_in,
    input  logic                      last,
    output logic [DIM-1:0][WIDTH-1:0] out_array,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIM-1:0]            sat,
    output logic                      busy
);

    state_t r_state;
    logic   r_out_valid;
    logic   r_busy;
    logic   w_clear;
    logic   w_count;

    // Start clears the lanes in IDLE and ACCUM, and in HOLD only together with
    // out_ready. A beat is counted only in ACCUM and never alongside start.
    assign w_clear = start && ((r_state != ST_HOLD) || out_ready);
    assign w_count = (r_state == ST_ACCUM) && en && !start;

    // Frame sequencing with registered out_valid/busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (!start && en && last) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_state <= ST_ACCUM;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                // NOTE: an explicit default recovers from the unused encoding instead of leaving it undefined.
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        unary_acc_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_clear (w_clear),
            .i_step  (w_count && unary_in[g]),
            .i_neg   (neg_in[g]),
            .o_acc   (out_array[g]),
            .o_sat   (sat[g])
        );
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_unary_to_binary_array.sv
// Directed bench for unary_to_binary_array: a reference model of the lane
// counters predicts each frame, expected frames queue on the last beat and
// are compared when out_valid appears.
module tb_unary_to_binary_array;
    import unary_to_binary_array_pkg::*;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [DIM-1:0][WIDTH-1:0] arr;
        logic [DIM-1:0]            sat;
    } frame_t;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      start;
    logic                      en;
    logic [DIM-1:0]            unary_in;
    logic [DIM-1:0]            neg_in;
    logic                      last;
    logic [DIM-1:0][WIDTH-1:0] out_array;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIM-1:0]            sat;
    logic                      busy;

    int             checks   = 0;
    int             failures = 0;
    frame_t         sb_q[$];
    int             m_acc[DIM];
    logic [DIM-1:0] m_sat;

    always #5 clk = ~clk;

    unary_to_binary_array #(
        .DIM   (DIM),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .en        (en),
        .unary_in  (unary_in),
        .neg_in    (neg_in),
        .last      (last),
        .out_array (out_array),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        en       = 1'b0;
        last     = 1'b0;
        unary_in = '0;
        neg_in   = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DIM; i++) m_acc[i] = 0;
        m_sat = '0;
    endtask

    task automatic model_beat(input logic [DIM-1:0] u, input logic [DIM-1:0] n);
        for (int i = 0; i < DIM; i++) begin
            if (u[i]) begin
                if (!n[i]) begin
                    if (m_acc[i] == SAT_MAX) m_sat[i] = 1'b1;
                    else m_acc[i] = m_acc[i] + 1;
                end else begin
                    if (m_acc[i] == SAT_MIN) m_sat[i] = 1'b1;
                    else m_acc[i] = m_acc[i] - 1;
                end
            end
        end
    endtask

    function automatic frame_t model_frame();
        frame_t f;
        for (int i = 0; i < DIM; i++) f.arr[i] = WIDTH'(m_acc[i]);
        f.sat = m_sat;
        return f;
    endfunction

    // Start cycle also presents a full beat, which must not be counted.
    task automatic do_start();
        @(negedge clk);
        idle_inputs();
        start    = 1'b1;
        en       = 1'b1;
        unary_in = '1;
        model_clear();
    endtask

    task automatic do_beat(input logic [DIM-1:0] u, input logic [DIM-1:0] n, input logic l);
        @(negedge clk);
        idle_inputs();
        en       = 1'b1;
        unary_in = u;
        neg_in   = n;
        last     = l;
        model_beat(u, n);
        if (l) sb_q.push_back(model_frame());
    endtask

    // Wait for out_valid, compare against the scoreboard, optionally stall
    // for `hold` cycles with noisy inputs, then complete the handshake.
    task automatic wait_frame(input string tag, input bit restart, input int hold);
        frame_t exp_f;
        bit     seen;
        int     lat;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            idle_inputs();
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(lat), 64'd1);
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (sb_q.size() == 0) begin
                check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
                exp_f = '0;
            end else begin
                exp_f = sb_q.pop_front();
                check({tag, "_array"}, 64'(out_array), 64'(exp_f.arr));
                check({tag, "_sat"}, 64'(sat), 64'(exp_f.sat));
            end
            for (int h = 0; h < hold; h++) begin
                start    = 1'($urandom_range(1));
                en       = 1'b1;
                last     = 1'b1;
                unary_in = DIM'($urandom);
                neg_in   = DIM'($urandom);
                @(negedge clk);
                check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_array"}, 64'(out_array), 64'(exp_f.arr));
                check({tag, "_hold_sat"}, 64'(sat), 64'(exp_f.sat));
            end
            idle_inputs();
            out_ready = 1'b1;
            start     = restart;
            if (restart) model_clear();
            @(negedge clk);
            out_ready = 1'b0;
            start     = 1'b0;
            check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
            check({tag, "_done_busy"}, 64'(busy), 64'(restart));
        end
    endtask

    initial begin
        logic [DIM-1:0] u;
        logic [DIM-1:0] n;

        reset_n   = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        model_clear();

        // Reset state
        #1;
        check("rst_array", 64'(out_array), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Beats without start are ignored in IDLE
        @(negedge clk);
        en = 1'b1; unary_in = '1; last = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(out_valid), 64'd0);

        // Five full beats -> 5 in every lane
        do_start();
        for (int k = 0; k < 5; k++) do_beat('1, '0, k == 4);
        wait_frame("basic", 1'b0, 0);

        // Mixed lanes, with a last-without-en cycle that must be ignored;
        // handshake together with start opens the next frame directly
        do_start();
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                @(negedge clk);
                idle_inputs();
                last = 1'b1; unary_in = '1;
            end
            u = {1'(k < 6), 1'b0, 1'b1, 1'(k < 3)};
            n = {1'(k % 2), 1'b0, 1'b1, 1'b0};
            do_beat(u, n, k == 6);
        end
        wait_frame("mixed", 1'b1, 0);

        // Positive saturation on lane 0 (frame opened by the restart above)
        for (int k = 0; k < 130; k++) do_beat(4'b0001, 4'b0000, k == 129);
        wait_frame("sat_pos", 1'b0, 0);

        // Negative saturation on lane 0
        do_start();
        for (int k = 0; k < 129; k++) do_beat(4'b0001, 4'b0001, k == 128);
        wait_frame("sat_neg", 1'b0, 0);

        // Backpressure: 10 stalled cycles with noisy inputs
        do_start();
        for (int k = 0; k < 3; k++) do_beat(4'b1010, 4'b0010, k == 2);
        wait_frame("bp", 1'b0, 10);

        // Abort: restart mid-frame discards the first three beats
        do_start();
        for (int k = 0; k < 3; k++) do_beat('1, '0, 1'b0);
        do_start();
        for (int k = 0; k < 2; k++) do_beat('1, '0, k == 1);
        wait_frame("abort", 1'b0, 0);

        // Reset mid-ACCUM: immediate clear, no output for the lost frame
        do_start();
        for (int k = 0; k < 4; k++) do_beat('1, '0, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("mid_rst_array", 64'(out_array), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_sat", 64'(sat), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        do_start();
        for (int k = 0; k < 2; k++) do_beat('1, 4'b0101, k == 1);
        wait_frame("post_rst", 1'b0, 0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
